uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between p_num_req byte-stream requesters using round-robin arbitration.
- Grant is held for a whole burst: until the requester's last-flagged byte, or until p_max_burst bytes.
- Sequences the transmitter's start/busy handshake byte by byte.
- Sits between the command/telemetry sources and the tx serializer, mirroring the rx path.

---
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin burst arbiter sharing one UART transmitter among p_num_req byte sources.
// Optional UART_ARB_HDR_EN prefixes each granted burst with header byte {4'hA, 1'b0, owner}.
module uart_tx_arbiter #(
    parameter int p_num_req      = 4,
    parameter int p_max_burst    = 16,
    parameter int p_busy_timeout = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [p_num_req-1:0]   i_req,
    input  logic [8*p_num_req-1:0] i_data,
    input  logic [p_num_req-1:0]   i_last,
    output logic [p_num_req-1:0]   o_ack,
    output logic [p_num_req-1:0]   o_grant,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_data,
    input  logic                   i_tx_busy,
    output logic                   o_err
);
    localparam int p_iw = $clog2(p_num_req);

    typedef enum logic [2:0] {IDLE, ARB, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state;
    logic [p_iw-1:0]   rr, owner, win, idx, rr_next;
    logic              found, last;
    logic [7:0]        cnt, tmr;
`ifdef UART_ARB_HDR_EN
    logic              hdr;
`endif

    assign rr_next = (owner == p_iw'(p_num_req - 1)) ? '0 : owner + 1'b1;

    // first requester at or after the rr pointer, wrapping
    always_comb begin
        win   = rr;
        found = 1'b0;
        idx   = rr;
        for (int k = 0; k < p_num_req; k++) begin
            if (!found && i_req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = (idx == p_iw'(p_num_req - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            rr         <= '0;
            owner      <= '0;
            cnt        <= '0;
            tmr        <= '0;
            last       <= 1'b0;
            o_ack      <= '0;
            o_grant    <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_err      <= 1'b0;
`ifdef UART_ARB_HDR_EN
            hdr        <= 1'b0;
`endif
        end else begin
            o_ack      <= '0;
            o_tx_start <= 1'b0;
            o_err      <= 1'b0;
            case (state)
                IDLE: if (|i_req && !i_tx_busy) state <= ARB;
                ARB: begin
                    if (!found) begin
                        state <= IDLE;
                    end else begin
                        owner        <= win;
                        o_grant      <= '0;
                        o_grant[win] <= 1'b1;
                        cnt          <= '0;
`ifdef UART_ARB_HDR_EN
                        o_tx_data    <= {4'hA, 1'b0, 3'(win)};
                        o_tx_start   <= 1'b1;
                        hdr          <= 1'b1;
                        state        <= START;
`else
                        state        <= LOAD;
`endif
                    end
                end
                LOAD: begin
                    if (i_req[owner]) begin
                        o_tx_data    <= i_data[8*owner +: 8];
                        last         <= i_last[owner];
                        o_ack[owner] <= 1'b1;
                        cnt          <= cnt + 8'd1;
                        o_tx_start   <= 1'b1;
                        state        <= START;
                    end else begin
                        o_grant <= '0;
                        rr      <= rr_next;
                        state   <= IDLE;
                    end
                end
                START: begin
                    tmr   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmr == 8'(p_busy_timeout - 1)) begin
                        o_err   <= 1'b1;
                        o_grant <= '0;
                        rr      <= rr_next;
                        state   <= IDLE;
                    end else begin
                        tmr <= tmr + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
`ifdef UART_ARB_HDR_EN
                        if (hdr) begin
                            hdr   <= 1'b0;
                            state <= LOAD;
                        end else
`endif
                        if (last || cnt == 8'(p_max_burst)) begin
                            o_grant <= '0;
                            rr      <= rr_next;
                            state   <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with requester/transmitter models and hand-computed byte orders.
// Header checks are active when UART_ARB_HDR_EN is defined.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, ack, grant, last_in;
    logic [31:0] data;
    logic        tx_start, busy, err;
    logic [7:0]  tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.p_num_req(4), .p_max_burst(16), .p_busy_timeout(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data), .i_last(last_in),
        .o_ack(ack), .o_grant(grant), .o_tx_start(tx_start), .o_tx_data(tx_data),
        .i_tx_busy(busy), .o_err(err)
    );

    typedef struct { int owner; logic [7:0] data; } rec_t;
    typedef struct { logic [3:0] req; int n; logic [15:0] ord; } vec_t;

    rec_t       got[$], exp_q[$], rec;
    vec_t       vecs[6];
    logic [7:0] bytes_q[4][32];
    logic       last_q[4][32];
    int         n[4], p[4], acks[4];
    int         passed = 0, total = 0, bcnt = 0, busy_len = 3, hdrs = 0;
    bit         tx_en = 1'b1, need_hdr = 1'b0;
    logic [3:0] prev_grant = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int idx_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return -1;
    endfunction

    // requesters, transmitter and tx logger all advance on the falling edge
    initial begin
        req = '0; data = '0; last_in = '0; busy = 1'b0;
        forever begin
            @(negedge clk);
            if (grant != prev_grant && grant != 4'd0) need_hdr = 1'b1;
            prev_grant = grant;
            if (tx_start) begin
                chk("start_while_busy", {31'd0, busy}, 32'd0);
`ifdef UART_ARB_HDR_EN
                if (need_hdr) begin
                    chk("header", {24'd0, tx_data}, {24'd0, 4'hA, 1'b0, 3'(idx_of(grant))});
                    hdrs++;
                    need_hdr = 1'b0;
                end else
`endif
                begin
                    rec.owner = idx_of(grant);
                    rec.data  = tx_data;
                    got.push_back(rec);
                end
            end
            if (tx_start && tx_en) bcnt = busy_len;
            else if (bcnt > 0) bcnt--;
            busy = bcnt > 0;
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) begin
                    chk("ack_owner", {31'd0, grant[i]}, 32'd1);
                    acks[i]++;
                    p[i]++;
                end
                req[i]          = p[i] < n[i];
                data[8*i +: 8]  = req[i] ? bytes_q[i][p[i]] : 8'h00;
                last_in[i]      = req[i] ? last_q[i][p[i]] : 1'b0;
            end
        end
    end

    task automatic fresh();
        for (int i = 0; i < 4; i++) begin n[i] = 0; p[i] = 0; end
    endtask

    task automatic load(input int r, input logic [7:0] d, input logic l);
        bytes_q[r][n[r]] = d;
        last_q[r][n[r]]  = l;
        n[r]++;
    endtask

    task automatic expect_b(input int r, input logic [7:0] d);
        rec_t e;
        e.owner = r;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic compare(input string name);
        chk({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk({name, "_owner"}, got[i].owner, exp_q[i].owner);
            chk({name, "_data"}, {24'd0, got[i].data}, {24'd0, exp_q[i].data});
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic drain();
        int quiet = 0;
        for (int i = 0; i < 3000 && quiet < 4; i++) begin
            @(negedge clk);
            quiet = (grant == 4'd0 && bcnt == 0 && req == 4'd0) ? quiet + 1 : 0;
        end
        if (quiet < 4) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin #500000; $display("FAIL watchdog expired"); $fatal(1); end

    initial begin
        logic [3:0] o;
        bit ok;
        int cyc;
        vecs[0] = '{4'b1101, 3, 16'h2300};
        vecs[1] = '{4'b0011, 2, 16'h1000};
        vecs[2] = '{4'b1000, 1, 16'h3000};
        vecs[3] = '{4'b1111, 4, 16'h0123};
        vecs[4] = '{4'b0110, 2, 16'h1200};
        vecs[5] = '{4'b0101, 2, 16'h0200};
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("reset_outputs", {14'd0, ack, grant, tx_start, tx_data, err}, 32'd0);
        @(negedge clk) rst = 1'b1;

        fresh(); load(1, 8'h55, 1'b1); expect_b(1, 8'h55);
        drain(); compare("single");
        chk("single_acks", acks[1], 1);
        chk("single_grant", {28'd0, grant}, 32'd0);

        // rr pointer carries from one vector to the next
        for (int v = 0; v < 6; v++) begin
            fresh();
            for (int i = 0; i < 4; i++) if (vecs[v].req[i]) load(i, {4'(v + 1), 4'(i)}, 1'b1);
            for (int k = 0; k < vecs[v].n; k++) begin
                o = vecs[v].ord[15 - 4*k -: 4];
                expect_b(int'(o), {4'(v + 1), o});
            end
            drain(); compare("rr_vec");
        end

        do_reset(); fresh();
        for (int j = 0; j < 3; j++) begin
            load(0, 8'(8'hB0 + j), j == 2);
            load(2, 8'(8'hC0 + j), j == 2);
        end
        for (int j = 0; j < 3; j++) expect_b(0, 8'(8'hB0 + j));
        for (int j = 0; j < 3; j++) expect_b(2, 8'(8'hC0 + j));
        drain(); compare("burst_pair");

        do_reset(); fresh();
        for (int j = 0; j < 20; j++) load(3, 8'(8'h40 + j), 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = grant == 4'b1000; end
        chk("max_burst_grant", {31'd0, ok}, 32'd1);
        load(0, 8'h77, 1'b1);
        for (int j = 0; j < 16; j++) expect_b(3, 8'(8'h40 + j));
        expect_b(0, 8'h77);
        for (int j = 16; j < 20; j++) expect_b(3, 8'(8'h40 + j));
        drain(); compare("max_burst");

        fresh(); tx_en = 1'b0; load(1, 8'h5D, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = tx_start; end
        chk("timeout_start", {31'd0, ok}, 32'd1);
        cyc = 0; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); cyc++; ok = err; end
        chk("timeout_cycles", cyc, 9);
        chk("timeout_grant", {28'd0, grant}, 32'd0);
        tx_en = 1'b1;
        @(negedge clk) chk("err_pulse", {31'd0, err}, 32'd0);
        expect_b(1, 8'h5D);
        drain(); compare("timeout");

        fresh(); busy_len = 10; load(2, 8'hE0, 1'b0); load(2, 8'hE1, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = ack[2]; end
        chk("mid_ack", {31'd0, ok}, 32'd1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("async_reset", {14'd0, ack, grant, tx_start, tx_data, err}, 32'd0);
        @(negedge clk) for (int i = 0; i < 4; i++) p[i] = n[i];
        @(negedge clk) rst = 1'b1;
        busy_len = 3;
        drain(); got.delete();
        fresh(); load(3, 8'h33, 1'b1); load(1, 8'h31, 1'b1);
        expect_b(1, 8'h31); expect_b(3, 8'h33);
        drain(); compare("rr_after_reset");

`ifdef UART_ARB_HDR_EN
        begin : hdr_seq
            int h0, a0;
            h0 = hdrs; a0 = acks[2];
            fresh(); load(2, 8'h11, 1'b1); expect_b(2, 8'h11);
            drain(); compare("hdr");
            chk("hdr_count", hdrs - h0, 1);
            chk("hdr_acks", acks[2] - a0, 1);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
